// File: rtl/config_frame_writer_pkg.sv
// Shared types and constants for the column configuration frame loader.
// Imported by the loader top and its strobe decoder.
package config_frame_pkg;

    typedef enum logic [1:0] {
        IDLE,
        HEADER,
        DATA,
        STROBE
    } cfgState_t;

    localparam int unsigned DESYNC_BIT = 31;
    localparam int unsigned IDX_LSB    = 0;
    localparam int unsigned IDX_MSB    = 7;
    localparam int unsigned IDX_W      = IDX_MSB - IDX_LSB + 1;

    localparam logic [31:0] SYNC_WORD  = 32'hFAB0_FAB1;

endpackage

// File: rtl/config_frame_writer_if.sv
// Valid/ready config word stream feeding the column frame loader.
interface config_frame_writer_if;

    logic [31:0] WordIn;
    logic        WordValid;
    logic        WordReady;

    modport master (output WordIn, output WordValid, input WordReady);
    modport slave  (input WordIn, input WordValid, output WordReady);

endinterface

// File: rtl/config_frame_writer_decoder.sv
// Frame index to one-hot frame strobe; all-zero when disabled or index out of range.
module frame_strobe_decoder
    import config_frame_pkg::*;
#(
    parameter int unsigned MaxFramesPerCol = 20
) (
    input  logic [IDX_W-1:0]           idx,
    input  logic                       enable,
    output logic [MaxFramesPerCol-1:0] strobe
);

    always_comb begin
        strobe = '0;
        for (int unsigned i = 0; i < MaxFramesPerCol; i++) begin
            if (enable && (32'(idx) == i)) begin
                strobe[i] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/config_frame_writer.sv
// Column-level configuration loader: syncs on the config stream, assembles one
// frame of per-row words and pulses the matching one-hot FrameStrobe.
module config_frame_writer
    import config_frame_pkg::*;
#(
    parameter int unsigned MaxFramesPerCol = 20,
    parameter int unsigned FrameBitsPerRow = 32,
    parameter int unsigned NumRows         = 16,
    parameter logic [31:0] SyncWord        = SYNC_WORD
) (
    input  logic                               CLK,
    input  logic                               RST,
    config_frame_writer_if.slave               wordBus,
    output logic [NumRows*FrameBitsPerRow-1:0] FrameData,
    output logic [MaxFramesPerCol-1:0]         FrameStrobe,
    output logic                               Busy,
    output logic                               FrameErr,
    output logic [15:0]                        FramesDone
);

    localparam int unsigned ROW_W = (NumRows > 1) ? $clog2(NumRows) : 1;

    generate
        if (FrameBitsPerRow != 32) begin : gBadRowWidth
            $error("config_frame_writer: FrameBitsPerRow must be 32");
        end
    endgenerate

    cfgState_t state, nextState;

    logic [IDX_W-1:0]                        idx;
    logic                                    drop;
    logic [ROW_W-1:0]                        rowCnt;
    logic [NumRows-1:0][FrameBitsPerRow-1:0] frameRows;

    logic             fire;
    logic             latchHeader;
    logic             writeRow;
    logic [IDX_W-1:0] hdrIdx;
    logic             hdrOutOfRange;

    assign wordBus.WordReady = (state != STROBE);
    assign fire              = wordBus.WordValid && wordBus.WordReady;
    assign hdrIdx            = wordBus.WordIn[IDX_MSB:IDX_LSB];
    assign hdrOutOfRange     = (32'(hdrIdx) >= MaxFramesPerCol);

    assign FrameData = frameRows;
    assign Busy      = (state != IDLE);

    always_comb begin
        nextState   = state;
        latchHeader = 1'b0;
        writeRow    = 1'b0;
        case (state)
            IDLE: begin
                if (fire && (wordBus.WordIn == SyncWord)) begin
                    nextState = HEADER;
                end
            end
            HEADER: begin
                // SyncWord has its desync bit set, so the re-sync match must win.
                if (fire) begin
                    if (wordBus.WordIn == SyncWord) begin
                        nextState = HEADER;
                    end else if (wordBus.WordIn[DESYNC_BIT]) begin
                        nextState = IDLE;
                    end else begin
                        latchHeader = 1'b1;
                        nextState   = DATA;
                    end
                end
            end
            DATA: begin
                if (fire) begin
                    writeRow = 1'b1;
                    if (rowCnt == ROW_W'(NumRows - 1)) begin
                        nextState = STROBE;
                    end
                end
            end
            STROBE:  nextState = HEADER;
            default: nextState = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state      <= IDLE;
            idx        <= '0;
            drop       <= 1'b0;
            rowCnt     <= '0;
            frameRows  <= '0;
            FrameErr   <= 1'b0;
            FramesDone <= '0;
        end else begin
            state <= nextState;
            if (latchHeader) begin
                idx    <= hdrIdx;
                drop   <= hdrOutOfRange;
                rowCnt <= '0;
                if (hdrOutOfRange) begin
                    FrameErr <= 1'b1;
                end
            end
            if (writeRow) begin
                frameRows[rowCnt] <= wordBus.WordIn;
                rowCnt            <= rowCnt + ROW_W'(1);
            end
            if ((state == STROBE) && !drop && (FramesDone != '1)) begin
                FramesDone <= FramesDone + 16'd1;
            end
        end
    end

    frame_strobe_decoder #(
        .MaxFramesPerCol(MaxFramesPerCol)
    ) uStrobeDecoder (
        .idx   (idx),
        .enable((state == STROBE) && !drop),
        .strobe(FrameStrobe)
    );

endmodule

// File: tb/tb_config_frame_writer.sv
// Directed bench for config_frame_writer: expected strobes are queued as frames are
// driven and checked (vector, cycle, data) when the strobe appears.
module tb_config_frame_writer;
    import config_frame_pkg::*;

    localparam int unsigned NF = 20;
    localparam int unsigned NR = 16;
    localparam logic [31:0] SYNC = 32'hFAB0_FAB1;

    logic           CLK = 1'b0;
    logic           RST = 1'b1;
    logic [NR*32-1:0] FrameData;
    logic [NF-1:0]  FrameStrobe;
    logic           Busy;
    logic           FrameErr;
    logic [15:0]    FramesDone;

    config_frame_writer_if bus();

    config_frame_writer #(
        .MaxFramesPerCol(NF),
        .FrameBitsPerRow(32),
        .NumRows(NR),
        .SyncWord(SYNC)
    ) dut (
        .CLK        (CLK),
        .RST        (RST),
        .wordBus    (bus),
        .FrameData  (FrameData),
        .FrameStrobe(FrameStrobe),
        .Busy       (Busy),
        .FrameErr   (FrameErr),
        .FramesDone (FramesDone)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [NF-1:0]    strobe;
        longint           cyc;
        logic [NR*32-1:0] data;
    } expStrobe_t;

    expStrobe_t       sb[$];
    int               testsRun  = 0;
    int               failCount = 0;
    longint           cyc       = 0;
    int               readyLow  = 0;
    logic [NF-1:0]    prevStrobe = '0;
    logic [NR*32-1:0] expData    = '0;

    always @(posedge CLK) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        testsRun++;
        assert (obs === exp) else begin
            failCount++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Strobe monitor: pops the scoreboard whenever any strobe bit is seen.
    always @(negedge CLK) begin
        expStrobe_t e;
        if (bus.WordReady !== 1'b1) readyLow++;
        if (FrameStrobe !== '0) begin
            check("strobe_onehot", 512'($onehot(FrameStrobe)), 512'(1));
            check("strobe_single_cycle", 512'(prevStrobe), 512'(0));
            if (sb.size() == 0) begin
                check("unexpected_strobe", 512'(FrameStrobe), 512'(0));
            end else begin
                e = sb.pop_front();
                check("strobe_vec", 512'(FrameStrobe), 512'(e.strobe));
                check("strobe_cycle", 512'(cyc), 512'(e.cyc));
                check("strobe_data", 512'(FrameData), 512'(e.data));
            end
        end
        prevStrobe = FrameStrobe;
    end

    task automatic sendWord(input logic [31:0] w, input bit gap, output longint acc);
        bit done;
        done = 1'b0;
        acc  = -1;
        @(negedge CLK);
        if (gap && ($urandom_range(1, 0) == 1)) @(negedge CLK);
        bus.WordIn    = w;
        bus.WordValid = 1'b1;
        for (int t = 0; t < 20 && !done; t++) begin
            if (bus.WordReady === 1'b1) begin
                acc  = cyc + 1;
                done = 1'b1;
                @(posedge CLK);
                #1 bus.WordValid = 1'b0;
            end else begin
                @(negedge CLK);
            end
        end
        bus.WordValid = 1'b0;
        check("ready_timeout", 512'(done), 512'(1));
    endtask

    task automatic sendFrame(input logic [7:0] idx, input logic [31:0] base, input bit gap,
                             input int specRow, input logic [31:0] specWord);
        longint acc;
        logic [31:0] w;
        sendWord({24'h0, idx}, gap, acc);
        for (int r = 0; r < NR; r++) begin
            w = (r == specRow) ? specWord : base + 32'(r);
            sendWord(w, gap, acc);
            expData[r*32 +: 32] = w;
        end
        if (idx < NF) sb.push_back('{strobe: NF'(1) << idx, cyc: acc, data: expData});
    endtask

    task automatic checkResetState(input string tag);
        check({tag, "_data"}, 512'(FrameData), 512'(0));
        check({tag, "_strobe"}, 512'(FrameStrobe), 512'(0));
        check({tag, "_err"}, 512'(FrameErr), 512'(0));
        check({tag, "_done"}, 512'(FramesDone), 512'(0));
        check({tag, "_busy"}, 512'(Busy), 512'(0));
        check({tag, "_ready"}, 512'(bus.WordReady), 512'(1));
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        longint acc;
        int rl0;
        bus.WordIn    = '0;
        bus.WordValid = 1'b0;

        // Reset
        RST = 1'b1;
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        checkResetState("reset");
        RST = 1'b0;

        // Words before sync are discarded
        repeat (3) sendWord(32'hDEAD_BEEF, 1'b0, acc);
        sendWord(32'h0000_0003, 1'b0, acc);
        for (int r = 0; r < 4; r++) sendWord(32'h0000_1000 + 32'(r), 1'b0, acc);
        @(negedge CLK);
        check("nosync_busy", 512'(Busy), 512'(0));
        check("nosync_data", 512'(FrameData), 512'(0));
        check("nosync_done", 512'(FramesDone), 512'(0));

        // Basic frame, with a re-sync in HEADER first
        sendWord(SYNC, 1'b0, acc);
        sendWord(SYNC, 1'b0, acc);
        @(negedge CLK);
        check("resync_busy", 512'(Busy), 512'(1));
        sendFrame(8'd3, 32'h0000_1000, 1'b0, -1, '0);
        repeat (2) @(negedge CLK);
        check("t1_done", 512'(FramesDone), 512'(1));
        check("t1_sb_empty", 512'(sb.size()), 512'(0));
        check("t1_data_hold", 512'(FrameData), 512'(expData));
        check("t1_busy_header", 512'(Busy), 512'(1));

        // Out-of-range index, then a valid frame 0
        sendFrame(8'd25, 32'h0000_2000, 1'b0, -1, '0);
        repeat (2) @(negedge CLK);
        check("t3_err", 512'(FrameErr), 512'(1));
        check("t3_done_unchanged", 512'(FramesDone), 512'(1));
        sendFrame(8'd0, 32'h0000_3000, 1'b0, -1, '0);
        repeat (2) @(negedge CLK);
        check("t3_done", 512'(FramesDone), 512'(2));
        check("t3_err_sticky", 512'(FrameErr), 512'(1));
        check("t3_sb_empty", 512'(sb.size()), 512'(0));

        // Random valid gaps, back-to-back frames 19 then 0
        rl0 = readyLow;
        sendFrame(8'd19, 32'h0000_4000, 1'b1, -1, '0);
        sendFrame(8'd0, 32'h0000_5000, 1'b1, -1, '0);
        repeat (2) @(negedge CLK);
        check("t4_ready_low", 512'(readyLow - rl0), 512'(2));
        check("t4_done", 512'(FramesDone), 512'(4));
        check("t4_sb_empty", 512'(sb.size()), 512'(0));

        // Reset mid-frame
        sendWord(32'h8000_0000, 1'b0, acc);
        sendWord(SYNC, 1'b0, acc);
        sendWord(32'h0000_0005, 1'b0, acc);
        for (int r = 0; r < 7; r++) sendWord(32'h0000_6000 + 32'(r), 1'b0, acc);
        @(negedge CLK);
        RST = 1'b1;
        @(negedge CLK);
        checkResetState("midreset");
        RST = 1'b0;
        expData = '0;
        sendWord(SYNC, 1'b0, acc);
        sendFrame(8'd7, 32'h0000_7000, 1'b0, -1, '0);
        repeat (2) @(negedge CLK);
        check("t5_done", 512'(FramesDone), 512'(1));
        check("t5_sb_empty", 512'(sb.size()), 512'(0));

        // Desync from HEADER; sync word stored as data inside DATA
        sendWord(32'h8000_0000, 1'b0, acc);
        @(negedge CLK);
        check("t6_desync_busy", 512'(Busy), 512'(0));
        sendWord(SYNC, 1'b0, acc);
        sendFrame(8'd2, 32'h0000_8000, 1'b0, 4, SYNC);
        repeat (2) @(negedge CLK);
        check("t6_done", 512'(FramesDone), 512'(2));
        check("t6_row4", 512'(FrameData[4*32 +: 32]), 512'(SYNC));
        check("t6_sb_empty", 512'(sb.size()), 512'(0));

        repeat (3) @(negedge CLK);
        $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
        $finish;
    end

endmodule
